srio2udp_interface: RTL and testbench
=====================================

Name: srio2udp_interface

Overview:
Return-path width converter: takes 64-bit SRIO-side beat stream (frame-delimited, byte keeps, frame length) and serialises it into the 32-bit UDP-side stream feeding the UDP transmit path.
- Single clock domain; the caller places any clock crossing upstream.
- Mirrors the packing of the UDP-to-SRIO direction:
  - Upper 32-bit half is the earlier word.
  - Odd trailing word of a frame sits in the lower half, with keep[7:4]=0.
- Adds a 2-entry input buffer, a half-select FSM and a frame byte-count check.

Parameters:
DATA_WIDTH, 64, SRIO-side data width; only 64 supported
LEN_WIDTH, 16, width of the frame length field, in bytes
BUF_DEPTH, 2, input beat buffer entries; power of two, ≥2

Ports:
clk_udp  in  1  clock
reset_udp_n  in  1  asynchronous active-low reset
srio_data_in  in  64  input beat data; [63:32] is emitted first
srio_keep_in  in  8  byte enables; [7:4] upper half, [3:0] lower half
srio_valid_in  in  1  input beat valid
srio_first_in  in  1  first beat of frame
srio_last_in  in  1  last beat of frame
srio_length_in  in  16  frame byte length; sampled with first beat
srio_ready_out  out  1  input ready (buffer not full)
udp_data_out  out  32  output word
udp_keep_out  out  4  output byte enables
udp_valid_out  out  1  output valid
udp_first_out  out  1  first word of frame
udp_last_out  out  1  last word of frame
udp_length_out  out  16  frame length, held for the whole frame
udp_ready_in  in  1  downstream ready
len_err_out  out  1  1-cycle pulse: counted bytes ≠ length

Behaviour:
Reset and handshakes:
- Reset (async assert, sync deassert internally) clears the buffer, FSM, counters and all outputs to 0, including srio_ready_out.
- srio_ready_out goes to 1 on the first clock after deassert.
- Input transfer occurs on srio_valid_in & srio_ready_out.
- srio_ready_out = buffer not full. It is registered-free combinational from the occupancy count, not from srio_valid_in.
- Output transfer occurs on udp_valid_out & udp_ready_in.
- While udp_valid_out=1 & udp_ready_in=0, all udp_* outputs hold stable.

Input buffer:
- BUF_DEPTH-entry FIFO holding {data, keep, first, last, length}.
- Simultaneous push and pop when full is allowed: pop frees the entry the same cycle, and the push is accepted only if srio_ready_out was already 1.

FSM (registered output stage):
- IDLE: nothing loaded. If the buffer is non-empty, pop the head into the working register and go to the first emitting state:
  - HI if keep[7:4]≠0
  - else LO
- HI: present [63:32] and keep[7:4].
  - udp_first_out = entry.first.
  - udp_last_out = entry.last & keep[3:0]==0.
  - On transfer: go to LO if keep[3:0]≠0; otherwise go to NEXT.
- LO: present [31:0] and keep[3:0].
  - udp_first_out = entry.first & (HI was skipped).
  - udp_last_out = entry.last.
  - On transfer: go to NEXT.
- NEXT is a combinational decision, not a state: if the buffer is non-empty, load the next entry in the same cycle, giving no bubble; else go to IDLE.
- Degenerate beat with keep=8'h00:
  - If last: emit one LO word with keep 4'h0 and last=1, closing the frame.
  - If not last: the beat is dropped silently.

Latency and throughput:
- Latency: a beat accepted at cycle N, with the buffer empty and FSM in IDLE, drives udp_valid_out at N+1.
- Sustained rate is 1 input beat per 2 cycles. Frames pass back-to-back with no idle cycle.

Frame tracking:
- udp_length_out is loaded from entry.length when a first-flagged entry is loaded, and holds until the next first.
- Byte counter (LEN_WIDTH bits) is cleared on the first word and adds popcount(keep) on each output transfer.
- Wrap-around at 2^16 is permitted, and the compare is modulo 2^16.
- len_err_out is 1 for exactly the cycle of the last-word transfer when (count incl. that word) ≠ udp_length_out.

Input protocol errors:
- srio_first_in without a preceding last: the new frame restarts the counter, and no error is flagged for the truncated frame.
- srio_last_in on a non-first beat of a never-started frame: the words are passed through and the count is compared against the stale length.

Reset mid-frame:
- Partial frame is discarded.
- No last is emitted.
- Post-reset output starts only on a first-flagged beat; beats before it are dropped.

Test Plan:
1. One frame, 3 beats, keep FF/FF/FF, length 24, data 0x11112222_33334444… → 6 words in order 1111…,3333…,… with first on word 0, last on word 5, keep F each, len_err_out=0.
2. Length 20, last beat keep 8'h0F → 5 words; word 4 = lower half of beat 2, keep F, last=1, no HI emit for that beat.
3. udp_ready_in low for 3 cycles mid-frame while input streams → udp_* stable, srio_ready_out drops after 2 buffered beats, all 24 bytes delivered intact.
4. Length field 32 but 24 bytes sent → len_err_out single pulse coincident with last-word transfer.
5. Two frames back-to-back with udp_ready_in=1 → last word of A and first word of B on consecutive cycles; udp_length_out switches on B's first.
6. Assert reset_udp_n low mid-frame (async, between edges) → all outputs 0 immediately; next full frame passes cleanly with len_err_out=0.

Source files
------------

// File: rtl/srio2udp_interface.sv
// srio2udp_interface
//   Return-path width converter. Accepts a frame-delimited 64-bit beat stream
//   from the SRIO side and serialises each beat into 32-bit words for the UDP
//   transmit path. The upper half of a beat is the earlier word. An odd trailing
//   word sits in the lower half with keep[7:4]=0.
//   The converter has a small input FIFO, a half-select FSM with registered
//   outputs, and a per-frame byte-count check against the advertised length.
//
// Ports
//   clk_udp, reset_udp_n        clock, asynchronous active-low reset
//   srio_data_in/keep_in        beat payload and byte enables ([63:32] first)
//   srio_valid_in/ready_out     input handshake
//   srio_first_in/last_in       frame delimiters
//   srio_length_in              frame byte length, taken from the first beat
//   udp_data_out/keep_out       output word and byte enables
//   udp_valid_out/ready_in      output handshake
//   udp_first_out/last_out      output frame delimiters
//   udp_length_out              frame length, held for the whole frame
//   len_err_out                 pulse on the last-word transfer when the
//                               counted bytes differ from udp_length_out
//
// Handshake: a transfer happens on a cycle where valid and ready are both 1.
// valid never depends on ready. Once valid is 1 and ready is 0, the producer
// holds valid and the payload stable until the transfer takes place.
module srio2udp_interface #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                      clk_udp,
    input  logic                      reset_udp_n,
    input  logic [DATA_WIDTH-1:0]     srio_data_in,
    input  logic [DATA_WIDTH/8-1:0]   srio_keep_in,
    input  logic                      srio_valid_in,
    input  logic                      srio_first_in,
    input  logic                      srio_last_in,
    input  logic [LEN_WIDTH-1:0]      srio_length_in,
    output logic                      srio_ready_out,
    output logic [DATA_WIDTH/2-1:0]   udp_data_out,
    output logic [DATA_WIDTH/16-1:0]  udp_keep_out,
    output logic                      udp_valid_out,
    output logic                      udp_first_out,
    output logic                      udp_last_out,
    output logic [LEN_WIDTH-1:0]      udp_length_out,
    input  logic                      udp_ready_in,
    output logic                      len_err_out
);
    localparam int HALF_W = DATA_WIDTH / 2;
    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int KEEP_H = KEEP_W / 2;
    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(BUF_DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_W-1:0]     keep;
        logic                  first;
        logic                  last;
        logic [LEN_WIDTH-1:0]  length;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

    function automatic logic [LEN_WIDTH-1:0] popcount(input logic [KEEP_H-1:0] k);
        logic [LEN_WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < KEEP_H; i++) begin
            c = c + LEN_WIDTH'(k[i]);
        end
        return c;
    endfunction

    // Reset asserts asynchronously. Input acceptance starts only after the first
    // clock edge following deassertion, so nothing is captured during the
    // release.
    logic rst_done;
    always_ff @(posedge clk_udp or negedge reset_udp_n) begin
        if (!reset_udp_n) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // Input FIFO
    entry_t           mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;
    entry_t           head;

    // Ready comes from occupancy only. A pop on a full cycle frees space for
    // the next cycle, not for the current one.
    assign srio_ready_out = rst_done && (count != FULL_CNT);
    assign push           = srio_valid_in && srio_ready_out;
    assign head           = mem[rd_ptr];

    always_ff @(posedge clk_udp) begin
        if (push) begin
            mem[wr_ptr] <= {srio_data_in, srio_keep_in, srio_first_in,
                            srio_last_in, srio_length_in};
        end
    end

    always_ff @(posedge clk_udp or negedge reset_udp_n) begin
        if (!reset_udp_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Half-select FSM with registered outputs
    state_t            state;
    logic [HALF_W-1:0] wk_data_lo;
    logic [KEEP_H-1:0] wk_keep_lo;
    logic              wk_last;
    logic              seen_first;
    logic              xfer;
    logic              need_load;
    logic              drop;

    assign xfer = udp_valid_out && udp_ready_in;

    // A new entry is needed when idle, or when the current word is the last one
    // of its beat and is leaving now. The head is then loaded in the same
    // cycle, so there is no bubble.
    assign need_load = (state == IDLE) ||
                       (xfer && ((state == LO) || (wk_keep_lo == '0)));
    assign pop = need_load && (count != '0);

    // Beats outside a started frame (after reset) and empty non-last beats
    // produce no output words.
    assign drop = (!seen_first && !head.first) ||
                  ((head.keep == '0) && !head.last);

    always_ff @(posedge clk_udp or negedge reset_udp_n) begin
        if (!reset_udp_n) begin
            state          <= IDLE;
            wk_data_lo     <= '0;
            wk_keep_lo     <= '0;
            wk_last        <= 1'b0;
            seen_first     <= 1'b0;
            udp_data_out   <= '0;
            udp_keep_out   <= '0;
            udp_valid_out  <= 1'b0;
            udp_first_out  <= 1'b0;
            udp_last_out   <= 1'b0;
            udp_length_out <= '0;
        end else if (pop) begin
            if (head.first) seen_first <= 1'b1;
            if (drop) begin
                state         <= IDLE;
                udp_valid_out <= 1'b0;
                udp_first_out <= 1'b0;
                udp_last_out  <= 1'b0;
            end else begin
                wk_data_lo    <= head.data[HALF_W-1:0];
                wk_keep_lo    <= head.keep[KEEP_H-1:0];
                wk_last       <= head.last;
                udp_valid_out <= 1'b1;
                udp_first_out <= head.first;
                if (head.first) udp_length_out <= head.length;
                if (head.keep[KEEP_W-1:KEEP_H] != '0) begin
                    state        <= HI;
                    udp_data_out <= head.data[DATA_WIDTH-1:HALF_W];
                    udp_keep_out <= head.keep[KEEP_W-1:KEEP_H];
                    udp_last_out <= head.last && (head.keep[KEEP_H-1:0] == '0);
                end else begin
                    // If the upper half is empty, the lower word is emitted on
                    // its own. This also covers the keep=0 last beat, which
                    // closes the frame with an empty word.
                    state        <= LO;
                    udp_data_out <= head.data[HALF_W-1:0];
                    udp_keep_out <= head.keep[KEEP_H-1:0];
                    udp_last_out <= head.last;
                end
            end
        end else if (xfer && (state == HI) && (wk_keep_lo != '0)) begin
            state         <= LO;
            udp_data_out  <= wk_data_lo;
            udp_keep_out  <= wk_keep_lo;
            udp_first_out <= 1'b0;
            udp_last_out  <= wk_last;
        end else if (need_load) begin
            state         <= IDLE;
            udp_valid_out <= 1'b0;
            udp_first_out <= 1'b0;
            udp_last_out  <= 1'b0;
        end
    end

    // Frame byte counter. The count restarts on every first word, so a frame
    // truncated by a new first is never reported.
    logic [LEN_WIDTH-1:0] byte_cnt;
    logic [LEN_WIDTH-1:0] cnt_next;

    assign cnt_next    = (udp_first_out ? '0 : byte_cnt) + popcount(udp_keep_out);
    assign len_err_out = xfer && udp_last_out && (cnt_next != udp_length_out);

    always_ff @(posedge clk_udp or negedge reset_udp_n) begin
        if (!reset_udp_n) begin
            byte_cnt <= '0;
        end else if (xfer) begin
            byte_cnt <= cnt_next;
        end
    end
endmodule

// File: tb/tb_srio2udp_interface.sv
// tb_srio2udp_interface
//   Bench for srio2udp_interface. A behavioural model turns every accepted beat
//   into its expected output words (data, keep, first, last, length, len_err).
//   These words go into a queue that the output monitor drains. A table of
//   single-beat frames checks word and error counts. Hand-written sequences
//   cover backpressure, back-to-back frames and reset in the middle of a frame.
//   Randomized frames exercise the rest.
module tb_srio2udp_interface;
    localparam int EW = 55;

    logic        clk_udp;
    logic        reset_udp_n;
    logic [63:0] srio_data_in;
    logic [7:0]  srio_keep_in;
    logic        srio_valid_in;
    logic        srio_first_in;
    logic        srio_last_in;
    logic [15:0] srio_length_in;
    logic        srio_ready_out;
    logic [31:0] udp_data_out;
    logic [3:0]  udp_keep_out;
    logic        udp_valid_out;
    logic        udp_first_out;
    logic        udp_last_out;
    logic [15:0] udp_length_out;
    logic        udp_ready_in = 1'b0;
    logic        len_err_out;

    srio2udp_interface #(.DATA_WIDTH(64), .LEN_WIDTH(16), .BUF_DEPTH(2)) dut (
        .clk_udp(clk_udp),
        .reset_udp_n(reset_udp_n),
        .srio_data_in(srio_data_in),
        .srio_keep_in(srio_keep_in),
        .srio_valid_in(srio_valid_in),
        .srio_first_in(srio_first_in),
        .srio_last_in(srio_last_in),
        .srio_length_in(srio_length_in),
        .srio_ready_out(srio_ready_out),
        .udp_data_out(udp_data_out),
        .udp_keep_out(udp_keep_out),
        .udp_valid_out(udp_valid_out),
        .udp_first_out(udp_first_out),
        .udp_last_out(udp_last_out),
        .udp_length_out(udp_length_out),
        .udp_ready_in(udp_ready_in),
        .len_err_out(len_err_out)
    );

    // Clock and downstream ready
    initial clk_udp = 1'b0;
    always #5 clk_udp = ~clk_udp;

    logic ready_force_en  = 1'b1;
    logic ready_force_val = 1'b1;
    int   ready_pct       = 100;

    always begin
        @(posedge clk_udp);
        #1;
        udp_ready_in = ready_force_en ? ready_force_val
                                      : ($urandom_range(0, 99) < ready_pct);
    end

    // Scoreboard
    int n_vec  = 0;
    int n_miss = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model. It works on whole beats and frames, not on cycles.
    logic        m_seen = 1'b0;
    logic [15:0] m_len  = '0;
    logic [15:0] m_cnt  = '0;

    task automatic model_reset();
        exp_q.delete();
        m_seen = 1'b0;
        m_len  = '0;
        m_cnt  = '0;
    endtask

    task automatic model_beat(input logic [63:0] d, input logic [7:0] k,
                              input logic f, input logic l, input logic [15:0] len);
        logic [31:0] wd [2];
        logic [3:0]  wk [2];
        int          n;
        logic        wf;
        logic        wl;
        logic        err;
        n = 0;
        if (f) m_seen = 1'b1;
        if (!m_seen) return;
        if ((k == 8'h00) && !l) return;
        if (f) m_len = len;
        if (k[7:4] != 4'h0) begin
            wd[n] = d[63:32]; wk[n] = k[7:4]; n++;
        end
        if ((k[3:0] != 4'h0) || (k == 8'h00)) begin
            wd[n] = d[31:0]; wk[n] = k[3:0]; n++;
        end
        for (int i = 0; i < n; i++) begin
            wf    = f && (i == 0);
            wl    = l && (i == n - 1);
            m_cnt = (wf ? 16'd0 : m_cnt) + 16'($countones(wk[i]));
            err   = wl && (m_cnt != m_len);
            exp_q.push_back({wd[i], wk[i], wf, wl, m_len, err});
        end
    endtask

    // Output monitor. It samples on the falling edge, when the outputs are
    // settled for the coming rising edge.
    int cyc        = 0;
    int words_seen = 0;
    int errs_seen  = 0;
    int last_cyc   = 0;
    int gap        = -1;
    logic          hold_pending = 1'b0;
    logic [EW-1:0] held;
    logic [EW-1:0] act_w;
    logic [EW-1:0] exp_w;

    always @(negedge clk_udp) begin
        cyc++;
        if (reset_udp_n) begin
            act_w = {udp_data_out, udp_keep_out, udp_first_out, udp_last_out,
                     udp_length_out, len_err_out};
            if (hold_pending) begin
                check("hold_stable", 64'({act_w[EW-1:1], udp_valid_out}), 64'(held));
            end
            if (udp_valid_out && udp_ready_in) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(act_w), 64'd0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("word", 64'(act_w), 64'(exp_w));
                end
                words_seen++;
                if (len_err_out) errs_seen++;
                if (udp_first_out) gap = cyc - last_cyc;
                if (udp_last_out) last_cyc = cyc;
            end else begin
                check("len_err_idle", 64'(len_err_out), 64'd0);
            end
            hold_pending = udp_valid_out && !udp_ready_in;
            held = {act_w[EW-1:1], udp_valid_out};
        end else begin
            hold_pending = 1'b0;
        end
    end

    // Driver tasks (called at a falling edge, return at a falling edge)
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                             input logic f, input logic l, input logic [15:0] len);
        logic acc;
        acc = 1'b0;
        srio_data_in   = d;
        srio_keep_in   = k;
        srio_first_in  = f;
        srio_last_in   = l;
        srio_length_in = len;
        srio_valid_in  = 1'b1;
        for (int t = 0; t < 300 && !acc; t++) begin
            acc = srio_ready_out;
            @(negedge clk_udp);
        end
        srio_valid_in = 1'b0;
        check("accept", 64'(acc), 64'd1);
        if (acc) model_beat(d, k, f, l, len);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk_udp);
            t++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk_udp);
    endtask

    typedef struct {
        logic [7:0]  keep;
        logic [15:0] length;
        int          words;
        int          errs;
    } vec_t;

    vec_t        vt [9];
    int          w0;
    int          e0;
    int          nb;
    logic [7:0]  kk [4];
    logic [15:0] tot;
    logic        ff;
    logic        ll;

    initial begin
        reset_udp_n    = 1'b0;
        srio_data_in   = '0;
        srio_keep_in   = '0;
        srio_valid_in  = 1'b0;
        srio_first_in  = 1'b0;
        srio_last_in   = 1'b0;
        srio_length_in = '0;

        vt[0] = '{8'hFF, 16'd8, 2, 0};
        vt[1] = '{8'h0F, 16'd4, 1, 0};
        vt[2] = '{8'hF0, 16'd4, 1, 0};
        vt[3] = '{8'h00, 16'd0, 1, 0};
        vt[4] = '{8'h00, 16'd1, 1, 1};
        vt[5] = '{8'h03, 16'd2, 1, 0};
        vt[6] = '{8'hC1, 16'd3, 2, 0};
        vt[7] = '{8'hFF, 16'd7, 2, 1};
        vt[8] = '{8'h10, 16'd1, 1, 0};

        // Reset state and release
        repeat (3) @(negedge clk_udp);
        #1;
        check("rst_outputs", 64'({udp_data_out, udp_keep_out, udp_valid_out, udp_first_out,
                                  udp_last_out, udp_length_out, len_err_out}), 64'd0);
        check("rst_ready", 64'(srio_ready_out), 64'd0);
        @(posedge clk_udp);
        #3 reset_udp_n = 1'b1;
        #1 check("ready_before_clk", 64'(srio_ready_out), 64'd0);
        @(posedge clk_udp);
        #1 check("ready_after_clk", 64'(srio_ready_out), 64'd1);
        @(negedge clk_udp);

        // Single-beat frame table
        for (int i = 0; i < 9; i++) begin
            w0 = words_seen;
            e0 = errs_seen;
            send_beat({$urandom, $urandom}, vt[i].keep, 1'b1, 1'b1, vt[i].length);
            drain();
            check($sformatf("vec%0d_words", i), 64'(words_seen - w0), 64'(vt[i].words));
            check($sformatf("vec%0d_errs", i), 64'(errs_seen - e0), 64'(vt[i].errs));
        end

        // Three full beats, 24 bytes
        e0 = errs_seen;
        send_beat(64'h11112222_33334444, 8'hFF, 1'b1, 1'b0, 16'd24);
        send_beat(64'h55556666_77778888, 8'hFF, 1'b0, 1'b0, 16'd24);
        send_beat(64'h9999AAAA_BBBBCCCC, 8'hFF, 1'b0, 1'b1, 16'd24);
        drain();
        check("frame24_errs", 64'(errs_seen - e0), 64'd0);

        // 20 bytes, trailing lower-half word
        w0 = words_seen;
        send_beat(64'hA0A0A0A0_A1A1A1A1, 8'hFF, 1'b1, 1'b0, 16'd20);
        send_beat(64'hA2A2A2A2_A3A3A3A3, 8'hFF, 1'b0, 1'b0, 16'd20);
        send_beat(64'hA4A4A4A4_A5A5A5A5, 8'h0F, 1'b0, 1'b1, 16'd20);
        drain();
        check("frame20_words", 64'(words_seen - w0), 64'd5);

        // Backpressure while input keeps streaming
        ready_force_val = 1'b0;
        @(negedge clk_udp);
        fork
            begin
                send_beat(64'h01010101_02020202, 8'hFF, 1'b1, 1'b0, 16'd24);
                send_beat(64'h03030303_04040404, 8'hFF, 1'b0, 1'b0, 16'd24);
                send_beat(64'h05050505_06060606, 8'hFF, 1'b0, 1'b1, 16'd24);
            end
            begin
                repeat (6) @(negedge clk_udp);
                check("ready_full", 64'(srio_ready_out), 64'd0);
                check("valid_held", 64'(udp_valid_out), 64'd1);
                ready_force_val = 1'b1;
            end
        join
        drain();

        // Length mismatch: 32 advertised, 24 sent
        e0 = errs_seen;
        send_beat(64'hB0B0B0B0_B1B1B1B1, 8'hFF, 1'b1, 1'b0, 16'd32);
        send_beat(64'hB2B2B2B2_B3B3B3B3, 8'hFF, 1'b0, 1'b0, 16'd32);
        send_beat(64'hB4B4B4B4_B5B5B5B5, 8'hFF, 1'b0, 1'b1, 16'd32);
        drain();
        check("short_frame_errs", 64'(errs_seen - e0), 64'd1);

        // Back-to-back frames
        gap = -1;
        send_beat(64'hC0C0C0C0_C1C1C1C1, 8'hFF, 1'b1, 1'b0, 16'd16);
        send_beat(64'hC2C2C2C2_C3C3C3C3, 8'hFF, 1'b0, 1'b1, 16'd16);
        send_beat(64'hD0D0D0D0_D1D1D1D1, 8'hFF, 1'b1, 1'b0, 16'd12);
        send_beat(64'hD2D2D2D2_D3D3D3D3, 8'h0F, 1'b0, 1'b1, 16'd12);
        drain();
        check("b2b_gap", 64'(gap), 64'd1);

        // First without a preceding last: truncated frame is not flagged
        e0 = errs_seen;
        send_beat(64'hE0E0E0E0_E1E1E1E1, 8'hFF, 1'b1, 1'b0, 16'd40);
        send_beat(64'hE2E2E2E2_E3E3E3E3, 8'hFF, 1'b1, 1'b1, 16'd8);
        drain();
        check("restart_errs", 64'(errs_seen - e0), 64'd0);

        // Reset in the middle of a frame
        send_beat(64'hF0F0F0F0_F1F1F1F1, 8'hFF, 1'b1, 1'b0, 16'd24);
        send_beat(64'hF2F2F2F2_F3F3F3F3, 8'hFF, 1'b0, 1'b0, 16'd24);
        @(posedge clk_udp);
        #2 reset_udp_n = 1'b0;
        #1;
        check("midrst_outputs", 64'({udp_data_out, udp_keep_out, udp_valid_out, udp_first_out,
                                     udp_last_out, udp_length_out, len_err_out}), 64'd0);
        check("midrst_ready", 64'(srio_ready_out), 64'd0);
        model_reset();
        #4 reset_udp_n = 1'b1;
        #1 check("midrst_ready_hold", 64'(srio_ready_out), 64'd0);
        @(posedge clk_udp);
        #1 check("midrst_ready_up", 64'(srio_ready_out), 64'd1);
        @(negedge clk_udp);
        w0 = words_seen;
        e0 = errs_seen;
        send_beat(64'hF4F4F4F4_F5F5F5F5, 8'hFF, 1'b0, 1'b1, 16'd24);
        send_beat(64'h12345678_9ABCDEF0, 8'hFF, 1'b1, 1'b0, 16'd24);
        send_beat(64'h0FEDCBA9_87654321, 8'hFF, 1'b0, 1'b0, 16'd24);
        send_beat(64'h13572468_ACE0BDF1, 8'hFF, 1'b0, 1'b1, 16'd24);
        drain();
        check("postrst_words", 64'(words_seen - w0), 64'd6);
        check("postrst_errs", 64'(errs_seen - e0), 64'd0);

        // Randomized frames with random backpressure
        ready_force_en = 1'b0;
        for (int fr = 0; fr < 60; fr++) begin
            ready_pct = $urandom_range(30, 100);
            nb  = $urandom_range(1, 4);
            tot = '0;
            for (int b = 0; b < nb; b++) begin
                case ($urandom_range(0, 3))
                    0, 1:    kk[b] = 8'hFF;
                    2:       kk[b] = 8'($urandom);
                    default: kk[b] = ($urandom_range(0, 1) != 0) ? 8'h0F : 8'hF0;
                endcase
                tot = tot + 16'($countones(kk[b]));
            end
            if ($urandom_range(0, 3) == 0) tot = tot + 16'($urandom_range(1, 5));
            ff = ($urandom_range(0, 9) != 0);
            ll = ($urandom_range(0, 7) != 0);
            for (int b = 0; b < nb; b++) begin
                send_beat({$urandom, $urandom}, kk[b], ff && (b == 0),
                          ll && (b == nb - 1), tot);
                repeat ($urandom_range(0, 1)) @(negedge clk_udp);
            end
        end
        ready_force_en  = 1'b1;
        ready_force_val = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        n_miss++;
        $display("FAIL watchdog: simulation did not finish, queue depth %0d expected 0", exp_q.size());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
